// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared command encoding and sizing for the SPI memory back end
package spi_mem_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_SIZE = 8;

    typedef logic [1:0] spi_cmd_t;

    localparam spi_cmd_t CMD_WR_ADDR = 2'b00;
    localparam spi_cmd_t CMD_WR_DATA = 2'b01;
    localparam spi_cmd_t CMD_RD_ADDR = 2'b10;
    localparam spi_cmd_t CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_if.sv
// rtl/spi_ram_if.sv - command/read-data link between SPI slave and RAM back end
interface spi_ram_if;

    logic       rx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (output rx_valid, output rx_data, input tx_data, input tx_valid);
    modport slave  (input rx_valid, input rx_data, output tx_data, output tx_valid);

endinterface

// File: rtl/spi_ram_array.sv
// rtl/spi_ram_array.sv - byte storage with synchronous write and registered read
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [MEM_DEPTH];

    // Storage has no reset so it can map onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - executes SPI slave commands against a single-port byte RAM
module spi_ram
    import spi_mem_pkg::*;
#(
    parameter int MEM_DEPTH = spi_mem_pkg::MEM_DEPTH,
    parameter int ADDR_SIZE = spi_mem_pkg::ADDR_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_ram_if.slave    bus
);

    spi_cmd_t             cmd;
    logic [7:0]           payload;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 tx_valid_q;
    logic                 wr_en;
    logic                 rd_en;

    assign cmd     = spi_cmd_t'(bus.rx_data[9:8]);
    assign payload = bus.rx_data[7:0];
    assign wr_en   = bus.rx_valid && (cmd == CMD_WR_DATA);
    assign rd_en   = bus.rx_valid && (cmd == CMD_RD_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            tx_valid_q <= 1'b0;
        end else if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
                CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
                default:     ;
            endcase
            // Any accepted non-read command retires the previous read result.
            tx_valid_q <= rd_en;
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (payload),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (bus.tx_data)
    );

    assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_spi_ram.sv
// tb/tb_spi_ram.sv - vector table, corner sequences and randomized model check for spi_ram
module tb_spi_ram;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    spi_ram_if bus ();

    spi_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] cmd;
        logic       chk_data;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[$];

    // Reference model: what the memory holds and what the output should show.
    logic [7:0] m_mem [256];
    bit         m_written [256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;
    logic [7:0] m_tx;
    bit         m_tx_known;
    bit         m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wr_addr  = 8'h00;
        m_rd_addr  = 8'h00;
        m_tx       = 8'h00;
        m_tx_known = 1'b1;
        m_valid    = 1'b0;
    endtask

    task automatic model_apply(input logic [9:0] c);
        logic [7:0] p;
        p = c[7:0];
        m_valid = 1'b0;
        case (c[9:8])
            2'b00: m_wr_addr = p;
            2'b01: begin m_mem[m_wr_addr] = p; m_written[m_wr_addr] = 1'b1; end
            2'b10: m_rd_addr = p;
            default: begin
                m_valid    = 1'b1;
                m_tx       = m_mem[m_rd_addr];
                m_tx_known = m_written[m_rd_addr];
            end
        endcase
    endtask

    task automatic step(input logic v, input logic [9:0] d);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        if (v) model_apply(d);
    endtask

    task automatic check_model(input string name);
        check({name, "_valid"}, 32'(bus.tx_valid), 32'(m_valid));
        if (m_tx_known) check({name, "_data"}, 32'(bus.tx_data), 32'(m_tx));
    endtask

    task automatic add(input logic [9:0] c, input logic cd, input logic [7:0] ed, input logic ev);
        vec_t v;
        v.cmd = c; v.chk_data = cd; v.exp_data = ed; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] rc;
        logic [7:0] ra;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) m_written[i] = 1'b0;
        model_reset();
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_data", 32'(bus.tx_data), 32'h00);
        check("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, two locations, last-write-wins, extreme addresses.
        add(10'h001, 0, 8'h00, 0); add(10'h132, 0, 8'h00, 0);
        add(10'h201, 0, 8'h00, 0); add(10'h3FF, 1, 8'h32, 1);
        add(10'h002, 1, 8'h32, 0); add(10'h155, 0, 8'h00, 0);
        add(10'h003, 0, 8'h00, 0); add(10'h1A0, 0, 8'h00, 0);
        add(10'h202, 0, 8'h00, 0); add(10'h300, 1, 8'h55, 1);
        add(10'h203, 1, 8'h55, 0); add(10'h3AB, 1, 8'hA0, 1);
        add(10'h0FF, 0, 8'h00, 0); add(10'h111, 0, 8'h00, 0);
        add(10'h1EE, 0, 8'h00, 0); add(10'h2FF, 0, 8'h00, 0);
        add(10'h35A, 1, 8'hEE, 1); add(10'h000, 0, 8'h00, 0);
        add(10'h166, 0, 8'h00, 0); add(10'h177, 0, 8'h00, 0);
        add(10'h200, 0, 8'h00, 0); add(10'h312, 1, 8'h77, 1);
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].cmd);
            check($sformatf("vec%0d_valid", i), 32'(bus.tx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_data", i), 32'(bus.tx_data), 32'(vecs[i].exp_data));
        end

        // Idle cycles hold the read result even with garbage on rx_data.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 10'($urandom));
            check("hold_valid", 32'(bus.tx_valid), 32'h1);
            check("hold_data", 32'(bus.tx_data), 32'h77);
        end
        step(1'b1, 10'h000);
        check("clear_valid", 32'(bus.tx_valid), 32'h0);
        check("clear_keep_data", 32'(bus.tx_data), 32'h77);

        // Mid-run asynchronous reset with a read command pending.
        step(1'b1, 10'h0FF);
        step(1'b1, 10'h2FF);
        step(1'b1, 10'h300);
        check("pre_reset_data", 32'(bus.tx_data), 32'hEE);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 10'h3C0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", 32'(bus.tx_data), 32'h00);
        check("async_reset_valid", 32'(bus.tx_valid), 32'h0);
        @(posedge clk);
        #1;
        check("pending_lost_valid", 32'(bus.tx_valid), 32'h0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 10'h1C3);
        step(1'b1, 10'h300);
        check("post_reset_addr_data", 32'(bus.tx_data), 32'hC3);
        step(1'b1, 10'h2FF);
        step(1'b1, 10'h300);
        check("mem_survives_reset", 32'(bus.tx_data), 32'hEE);

        // Randomized traffic over a small address pool so reads hit written data.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            rc = {2'($urandom), ra};
            if (rc[9:8] == 2'b01) rc[7:0] = 8'($urandom);
            step(($urandom_range(0, 3) != 0), rc);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
